// File: rtl/async_evt_pkg.sv
// Shared types and constants for the asynchronous strobe arbiter.
// Holds the FSM states, the synchronizer reset level and the index-width helper.
package async_evt_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Strobes idle high, so the synchronizer resets to the inactive level.
    localparam logic SYNC_RST = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/evt_sync_cell.sv
// One strobe channel: two-stage synchronizer (negedge then posedge)
// followed by a falling-edge detector on the synchronized level.
module evt_sync_cell
    import async_evt_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_fall
);

    logic r_s0;
    logic r_s1;
    logic r_prev;

    // Sampling the first stage on the falling edge saves half a cycle of latency.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) r_s0 <= SYNC_RST;
        else        r_s0 <= i_async;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= SYNC_RST;
            r_prev <= SYNC_RST;
        end else begin
            r_s1   <= r_s0;
            r_prev <= r_s1;
        end
    end

    assign o_fall = r_prev & ~r_s1;

endmodule

// File: rtl/async_evt_arbiter.sv
// Latches falling edges of N asynchronous active-low strobes as pending events
// and hands them one at a time, round-robin, to a valid/ready consumer.
module async_evt_arbiter
    import async_evt_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  async_in,
    input  logic [N-1:0]  en,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [IW-1:0] evt_id,
    output logic          evt_ovf,
    output logic [N-1:0]  pend_o
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  w_fall_raw;
    logic [N-1:0]  w_fall;
    logic [N-1:0]  w_acc_vec;
    logic [N-1:0]  r_pend;
    logic [N-1:0]  r_ovf;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_evt_id;
    logic [IW-1:0] w_pick;
    logic          w_pick_vld;
    logic          w_acc;

    for (genvar g = 0; g < N; g++) begin : g_sync
        evt_sync_cell u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_async (async_in[g]),
            .o_fall  (w_fall_raw[g])
        );
    end

    assign w_fall = w_fall_raw & en;
    assign w_acc  = (r_state == OFFER) && evt_ready;

    always_comb begin
        w_acc_vec = '0;
        if (w_acc) w_acc_vec[r_evt_id] = 1'b1;
    end

    // A new edge landing in the acceptance cycle re-arms the channel without counting as lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_acc_vec) | w_fall;
            r_ovf  <= (r_ovf & ~w_acc_vec) | (w_fall & r_pend & ~w_acc_vec);
        end
    end

    // First pending channel at or after r_ptr, wrapping modulo N.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_pick_vld && r_pend[IW'((int'(r_ptr) + k) % N)]) begin
                w_pick_vld = 1'b1;
                w_pick     = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_vld) w_state_nxt = OFFER;
            OFFER:   if (evt_ready)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_id <= '0;
            r_ptr    <= '0;
        end else begin
            if (r_state == IDLE && w_pick_vld) r_evt_id <= w_pick;
            if (w_acc) r_ptr <= (r_evt_id == IW'(N - 1)) ? '0 : r_evt_id + IW'(1);
        end
    end

    always_comb begin
        evt_valid = 1'b0;
        evt_ovf   = 1'b0;
        if (r_state == OFFER) begin
            evt_valid = 1'b1;
            evt_ovf   = r_ovf[r_evt_id];
        end
    end

    assign evt_id = r_evt_id;
    assign pend_o = r_pend;

endmodule

// File: tb/tb_async_evt_arbiter.sv
// Bench for async_evt_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against an event-level reference model.
module tb_async_evt_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  async_in = '1;
    logic [N-1:0]  en = '1;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic          evt_ovf;
    logic [N-1:0]  pend_o;

    int n_checks = 0;
    int n_errors = 0;

    async_evt_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_in  (async_in),
        .en        (en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_ovf   (evt_ovf),
        .pend_o    (pend_o)
    );

    always #5 clk = ~clk;

    // Reference model: an edge seen in consecutive negedge samples becomes pending two
    // posedges after its first low sample; an idle scheduler offers the next pending
    // channel round-robin and keeps it until ready.
    logic [N-1:0]  m_samp = '1;
    logic [N-1:0]  m_seen = '1;
    logic [N-1:0]  m_due = '0;
    logic [N-1:0]  m_pend = '0;
    logic [N-1:0]  m_ovf = '0;
    int            m_offer = -1;
    int            m_ptr = 0;
    logic          m_exp_valid = 1'b0;
    logic          m_exp_ovf = 1'b0;
    logic [IW-1:0] m_exp_id = '0;

    always @(negedge clk) m_samp = rst_n ? async_in : '1;

    always @(posedge clk) begin : model_pos
        logic [N-1:0] old_pend;
        logic [N-1:0] arrive;
        logic [N-1:0] acc_vec;
        int           j;
        if (!rst_n) begin
            m_seen = '1; m_due = '0; m_pend = '0; m_ovf = '0;
            m_offer = -1; m_ptr = 0;
        end else begin
            old_pend = m_pend;
            arrive   = m_due & en;
            acc_vec  = '0;
            if (m_offer >= 0) begin
                if (evt_ready) begin
                    acc_vec = N'(1) << m_offer;
                    m_ptr   = (m_offer + 1) % N;
                    m_offer = -1;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (m_offer < 0 && old_pend[j[IW-1:0]]) m_offer = j;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acc_vec[i[IW-1:0]]) begin
                    m_pend[i[IW-1:0]] = 1'b0;
                    m_ovf[i[IW-1:0]]  = 1'b0;
                end
                if (arrive[i[IW-1:0]]) begin
                    if (old_pend[i[IW-1:0]] && !acc_vec[i[IW-1:0]]) m_ovf[i[IW-1:0]] = 1'b1;
                    m_pend[i[IW-1:0]] = 1'b1;
                end
            end
            m_due  = m_seen & ~m_samp;
            m_seen = m_samp;
        end
        j = m_offer;
        m_exp_valid = (m_offer >= 0);
        m_exp_ovf   = (m_offer >= 0) ? m_ovf[j[IW-1:0]] : 1'b0;
        if (m_offer >= 0) m_exp_id = j[IW-1:0];
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; async_in = '1; en = '1; evt_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        async_in = '1; en = '1; evt_ready = 1'b0;
        #2;
        n_checks++;
        if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_async_valid: got %0b exp 0", evt_valid); end
        tick(); tick();
        n_checks++;
        if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b exp 0", evt_valid); end
        n_checks++;
        if (evt_id !== 2'd0) begin n_errors++; $display("FAIL reset_id: got %0d exp 0", evt_id); end
        n_checks++;
        if (evt_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %0b exp 0", evt_ovf); end
        n_checks++;
        if (pend_o !== 4'b0000) begin n_errors++; $display("FAIL reset_pend: got %b exp 0000", pend_o); end
        rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (evt_valid !== 1'b0 || pend_o !== 4'b0000) begin
            n_errors++; $display("FAIL reset_release_idle: got valid %0b pend %b exp 0 0000", evt_valid, pend_o);
        end
    endtask

    task automatic test_latency();
        int extra;
        evt_ready = 1'b1;
        async_in[2] = 1'b0;
        tick();
        n_checks++;
        if (pend_o !== 4'b0000 || evt_valid !== 1'b0) begin
            n_errors++; $display("FAIL lat_p1: got pend %b valid %0b exp 0000 0", pend_o, evt_valid);
        end
        tick();
        n_checks++;
        if (pend_o !== 4'b0100 || evt_valid !== 1'b0) begin
            n_errors++; $display("FAIL lat_p2: got pend %b valid %0b exp 0100 0", pend_o, evt_valid);
        end
        tick();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_ovf !== 1'b0) begin
            n_errors++; $display("FAIL lat_p3: got valid %0b id %0d ovf %0b exp 1 2 0", evt_valid, evt_id, evt_ovf);
        end
        tick();
        n_checks++;
        if (evt_valid !== 1'b0 || pend_o !== 4'b0000) begin
            n_errors++; $display("FAIL lat_accept: got valid %0b pend %b exp 0 0000", evt_valid, pend_o);
        end
        extra = 0;
        repeat (8) begin
            tick();
            if (evt_valid === 1'b1 || pend_o !== 4'b0000) extra++;
        end
        n_checks++;
        if (extra != 0) begin n_errors++; $display("FAIL lat_held_low_repeat: got %0d busy cycles exp 0", extra); end
        async_in[2] = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_round_robin();
        int ids[$];
        do_reset();
        evt_ready = 1'b1;
        async_in = 4'b0100;
        repeat (20) begin
            tick();
            if (evt_valid === 1'b1) ids.push_back(int'(evt_id));
        end
        n_checks++;
        if (ids.size() != 3 || ids[0] != 0 || ids[1] != 1 || ids[2] != 3) begin
            n_errors++; $display("FAIL rr_first: got %p exp '{0,1,3}", ids);
        end
        async_in = '1;
        repeat (3) tick();
        ids.delete();
        async_in = 4'b0110;
        repeat (12) begin
            tick();
            if (evt_valid === 1'b1) ids.push_back(int'(evt_id));
        end
        n_checks++;
        if (ids.size() != 2 || ids[0] != 0 || ids[1] != 3) begin
            n_errors++; $display("FAIL rr_wrap: got %p exp '{0,3}", ids);
        end
        async_in = '1;
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        async_in[1] = 1'b0; tick(); tick();
        async_in[1] = 1'b1; tick(); tick();
        async_in[1] = 1'b0; tick(); tick();
        async_in[1] = 1'b1; repeat (3) tick();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_ovf !== 1'b1 || pend_o !== 4'b0010) begin
            n_errors++;
            $display("FAIL ovf_offer: got valid %0b id %0d ovf %0b pend %b exp 1 1 1 0010", evt_valid, evt_id, evt_ovf, pend_o);
        end
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0 || pend_o !== 4'b0000) begin
            n_errors++; $display("FAIL ovf_accept: got valid %0b pend %b exp 0 0000", evt_valid, pend_o);
        end
        async_in[1] = 1'b0; tick(); tick();
        async_in[1] = 1'b1; tick();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_ovf !== 1'b0) begin
            n_errors++; $display("FAIL ovf_cleared: got valid %0b id %0d ovf %0b exp 1 1 0", evt_valid, evt_id, evt_ovf);
        end
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        tick();
    endtask

    task automatic test_accept_coincident();
        bit seen;
        evt_ready = 1'b0;
        async_in[0] = 1'b0; tick(); tick();
        async_in[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (evt_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || evt_id !== 2'd0) begin
            n_errors++; $display("FAIL coin_first_offer: got seen %0b id %0d exp 1 0", seen, evt_id);
        end
        async_in[0] = 1'b0; tick();
        evt_ready = 1'b1; tick();
        evt_ready = 1'b0;
        n_checks++;
        if (pend_o[0] !== 1'b1 || evt_valid !== 1'b0) begin
            n_errors++; $display("FAIL coin_repend: got pend0 %0b valid %0b exp 1 0", pend_o[0], evt_valid);
        end
        tick();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_ovf !== 1'b0) begin
            n_errors++; $display("FAIL coin_next_offer: got valid %0b id %0d ovf %0b exp 1 0 0", evt_valid, evt_id, evt_ovf);
        end
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        async_in[0] = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_enable_reset();
        int busy;
        en = 4'b0111;
        async_in[3] = 1'b0; repeat (3) tick();
        async_in[3] = 1'b1;
        busy = 0;
        repeat (6) begin
            tick();
            if (evt_valid === 1'b1 || pend_o !== 4'b0000) busy++;
        end
        n_checks++;
        if (busy != 0) begin n_errors++; $display("FAIL en_block: got %0d busy cycles exp 0", busy); end
        en = '1;
        evt_ready = 1'b0;
        async_in[2] = 1'b0; repeat (3) tick();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            n_errors++; $display("FAIL rst_pre_offer: got valid %0b id %0d exp 1 2", evt_valid, evt_id);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (evt_valid !== 1'b0 || pend_o !== 4'b0000) begin
            n_errors++; $display("FAIL rst_async_drop: got valid %0b pend %b exp 0 0000", evt_valid, pend_o);
        end
        async_in[2] = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        busy = 0;
        repeat (8) begin
            tick();
            if (evt_valid === 1'b1 || pend_o !== 4'b0000) busy++;
        end
        n_checks++;
        if (busy != 0) begin n_errors++; $display("FAIL rst_no_stale: got %0d busy cycles exp 0", busy); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            async_in  = async_in ^ N'($urandom & $urandom);
            evt_ready = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            tick();
            n_checks++;
            if (evt_valid !== m_exp_valid) begin
                n_errors++; $display("FAIL rnd_valid c%0d: got %0b exp %0b", c, evt_valid, m_exp_valid);
            end
            n_checks++;
            if (pend_o !== m_pend) begin
                n_errors++; $display("FAIL rnd_pend c%0d: got %b exp %b", c, pend_o, m_pend);
            end
            n_checks++;
            if (evt_ovf !== m_exp_ovf) begin
                n_errors++; $display("FAIL rnd_ovf c%0d: got %0b exp %0b", c, evt_ovf, m_exp_ovf);
            end
            if (m_exp_valid) begin
                n_checks++;
                if (evt_id !== m_exp_id) begin
                    n_errors++; $display("FAIL rnd_id c%0d: got %0d exp %0d", c, evt_id, m_exp_id);
                end
            end
        end
        async_in = '1; en = '1; evt_ready = 1'b1;
        repeat (12) tick();
        n_checks++;
        if (evt_valid !== 1'b0 || pend_o !== 4'b0000) begin
            n_errors++; $display("FAIL rnd_drain: got valid %0b pend %b exp 0 0000", evt_valid, pend_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_overflow();
        test_accept_coincident();
        test_enable_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/async_evt_arbiter.md
# async_evt_arbiter

Collects N asynchronous active-low strobe inputs (idle high), synchronizes each one, detects its falling edge and latches it as a pending event. A round-robin scheduler then hands the events one at a time to a single downstream consumer over a valid/ready handshake. The block sits between external or cross-domain strobe pins and the control FSMs that service them, replacing ad-hoc per-pin synchronizers.

## Interface
Parameters:
- N, 4, number of strobe channels (2..16)
- IW, $clog2(N), event index width (derived, not overridden)

Ports:
- clk  in  1  clock; rising edge, except synchronizer stage 0, which samples on the falling edge
- rst_n  in  1  reset, asynchronous, active-low
- async_in  in  N  asynchronous strobes, active-low, idle high
- en  in  N  per-channel enable; a 0 blocks new events, already-pending events are kept
- evt_valid  out  1  event offered
- evt_ready  in  1  consumer accepts the event when high with evt_valid
- evt_id  out  IW  channel index of the offered event
- evt_ovf  out  1  the offered channel lost one or more edges while it was pending
- pend_o  out  N  pending flags, for status reads

## Operation
- Per-channel synchronizer:
  - s0 samples async_in[i] on the negedge of clk.
  - s1 takes s0 on the posedge of clk.
  - Both stages reset to 1.
- Edge detect:
  - prev[i] registers s1 on the posedge, reset value 1.
  - fall[i] = prev[i] & ~s1[i] & en[i].
- Pending set: pend[i] is set on the posedge after fall[i].
- Overflow:
  - Condition: fall[i] with pend[i] already 1, and channel i not being accepted in that same cycle.
  - Action: ovf[i] <= 1.
  - A fall on channel i in the cycle it is accepted re-sets pend[i] and does not set ovf[i].
- Acceptance (evt_valid & evt_ready) clears pend[evt_id] and ovf[evt_id].
- FSM states:
  - IDLE: evt_valid = 0. If any pend bit is set, choose the first set index at or after ptr, scanning upward with wrap modulo N. Register it into evt_id, set evt_valid, go to OFFER.
  - OFFER: evt_valid = 1 and evt_id is held stable. On evt_ready, set ptr to evt_id+1 (wrapping N-1 to 0) and go to IDLE.
- evt_ovf = ovf[evt_id] while in OFFER, 0 otherwise.
- Clearing en[i] while channel i is being offered does not withdraw the offer.
- Throughput: at most one event per 2 cycles.

## Timing
- Reset values:
  - evt_valid = 0, evt_id = 0, evt_ovf = 0, pend_o = 0
  - ptr = 0, ovf = 0, FSM in IDLE
  - s0, s1, prev all 1
- Reset is asynchronous at any point, including during OFFER. The offer is dropped immediately, with no handshake.
- After reset release, an input held low produces exactly one event. Its first sample transitions from 1 to 0.
- Latency, counting from the first clk negedge that samples async_in[i] low (N0):
  - s1 goes low at posedge P1, the first posedge after N0.
  - pend[i] rises at P2.
  - evt_valid rises at P3, provided the FSM is in IDLE and i wins arbitration.
- Pulse width: a low pulse shorter than one clk period can be missed. A pulse of at least one period plus setup is always captured.
- Each falling edge produces one event. Holding the input low produces no repeat events.

## Structure
- Package async_evt_pkg holds:
  - the FSM state enum {IDLE, OFFER}
  - the reset constant for the synchronizer (1'b1)
  - an index-width function for IW
- Sub-module evt_sync_cell, instantiated N times:
  - contains the s0/s1 negedge-then-posedge stages and prev
  - output: fall (before en gating)
- The round-robin priority pick stays in the top level.

## Test plan
- Reset: rst_n low with all inputs high → all outputs 0, pend_o = 0.
- Latency: N=4, drive async_in[2] low once, evt_ready tied high:
  - evt_valid rises at P3 with evt_id = 2 and evt_ovf = 0
  - accepted on that cycle, pend_o returns to 0
  - holding the input low produces no second event
- Round-robin: channels 0, 1 and 3 fall in the same cycle, ready high → evt_id sequence 0, 1, 3.
  - Then channels 0 and 3 pend again with ptr = 0 (after 3 wrapped) → next is 0, then 3.
- Overflow: channel 1 pulses low twice while evt_ready = 0.
  - Offered with evt_id = 1 and evt_ovf = 1.
  - After acceptance, pend_o[1] = 0 and the ovf bit is cleared.
- Accept coincident with new edge: channel 0 falls in the acceptance cycle of channel 0.
  - pend_o[0] stays 1, and the next offer shows evt_ovf = 0.
- Enable and mid-operation reset:
  - en[3] = 0 while channel 3 falls → no event.
  - rst_n pulsed low during OFFER → evt_valid drops asynchronously, and no stale event appears after release.
